// File: rtl/uart_rx_core_if.sv
// Receive-side handshake bundle for uart_rx_core.
//   master : the receiver; drives the held word, its status flags and the
//            overrun pulse, and samples the consumer's rx_ready.
//   slave  : the consumer; samples the word and flags, and drives rx_ready.
// Signals:
//   rx_data     received word, LSB = first data bit on the line
//   rx_valid    rx_data / frame_err / parity_err hold a valid word
//   rx_ready    consumer accepts the word on a rising clock edge
//   frame_err   a stop bit of the held word sampled 0
//   parity_err  the held word failed its parity check
//   overrun_err one-cycle pulse: a completed frame was dropped
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with a one-word output register.
// Ports:
//   clk    system clock, all state updates on its rising edge
//   reset  asynchronous active-low reset
//   rxd    asynchronous serial line, idles high
//   rx     handshake bundle (master side): word, valid/ready, error flags
//   busy   high whenever the receiver is not in IDLE
// A frame is start bit, DATA_BITS data bits LSB first, optional parity bit
// and STOP_BITS stop bits. Each bit is decided by a 3-sample majority vote
// around the middle of the bit.
module uart_rx_core #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rxd,
  uart_rx_core_if.master rx,
  output logic           busy
);

  localparam int DIV_RAW = CLK_FREQUENCY / (OVERSAMPLE * BAUD_RATE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_V0   = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_V1   = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] SAMP_V2   = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                state;
  logic                  rxd_s1;
  logic                  rxd_s2;
  logic                  rxd_d;
  logic [DIV_W-1:0]      div_cnt;
  logic [SAMP_W-1:0]     samp_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  samp0;
  logic                  samp1;
  logic [DATA_BITS-1:0]  shreg;
  logic                  ferr_acc;
  logic                  perr_acc;

  logic tick;
  logic vote_now;
  logic bit_end;
  logic vote;
  logic last_stop;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Odd mode expects the XOR over data and parity bit to be 1, even mode 0.
  function automatic logic parity_fail(input logic [DATA_BITS-1:0] d,
                                       input logic p);
    logic x;
    x = (^d) ^ p;
    case (PARITY)
      1:       return ~x;
      2:       return x;
      default: return 1'b0;
    endcase
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign vote_now  = tick && (samp_cnt == SAMP_V2);
  assign bit_end   = tick && (samp_cnt == SAMP_LAST);
  // The third sample is taken live on the vote tick.
  assign vote      = maj3(samp0, samp1, rxd_s2);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      rxd_s1          <= 1'b1;
      rxd_s2          <= 1'b1;
      rxd_d           <= 1'b1;
      div_cnt         <= '0;
      samp_cnt        <= '0;
      bit_cnt         <= '0;
      stop_cnt        <= 1'b0;
      samp0           <= 1'b1;
      samp1           <= 1'b1;
      shreg           <= '0;
      ferr_acc        <= 1'b0;
      perr_acc        <= 1'b0;
      rx.rx_data      <= '0;
      rx.rx_valid     <= 1'b0;
      rx.frame_err    <= 1'b0;
      rx.parity_err   <= 1'b0;
      rx.overrun_err  <= 1'b0;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;

      rx.overrun_err <= 1'b0;
      // Acceptance clears valid; a frame completing in the same cycle
      // re-sets it further down.
      if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          div_cnt  <= '0;
          samp_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          ferr_acc <= 1'b0;
          perr_acc <= 1'b0;
          if (rxd_d && !rxd_s2) state <= S_START;
        end

        // Holding here until the line is high keeps a break from looking
        // like an endless stream of start bits.
        S_WAIT_HIGH: begin
          if (rxd_s2) state <= S_IDLE;
        end

        default: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
            if (samp_cnt == SAMP_V0) samp0 <= rxd_s2;
            if (samp_cnt == SAMP_V1) samp1 <= rxd_s2;
          end

          case (state)
            S_START: begin
              if (vote_now && vote) state <= S_IDLE;
              else if (bit_end)     state <= S_DATA;
            end

            S_DATA: begin
              if (vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
              if (bit_end) begin
                if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
            end

            S_PARITY: begin
              if (vote_now) perr_acc <= parity_fail(shreg, vote);
              if (bit_end)  state    <= S_STOP;
            end

            S_STOP: begin
              if (vote_now) begin
                if (last_stop) begin
                  // Frame ends at the vote; the rest of the stop bit is
                  // absorbed by WAIT_HIGH.
                  state <= S_WAIT_HIGH;
                  if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_data    <= shreg;
                    rx.frame_err  <= ferr_acc | ~vote;
                    rx.parity_err <= perr_acc;
                    rx.rx_valid   <= 1'b1;
                  end else begin
                    rx.overrun_err <= 1'b1;
                  end
                end else begin
                  ferr_acc <= ferr_acc | ~vote;
                end
              end
              if (bit_end && !last_stop) stop_cnt <= 1'b1;
            end

            default: state <= S_IDLE;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core.
// Two receivers share one clock: dut_a is 8N1 and dut_b is 8E1, both at
// 1.6 MHz / 100 kbaud / 16x oversampling, so one bit is 16 clocks.
// Words are checked by a scoreboard at the moment they are accepted.
module tb_uart_rx_core;

  localparam int BIT = 16;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    int         sel;
    logic [7:0] d;
    bit         par;
    logic       pbit;
    logic       stopb;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  logic clk;
  logic reset;
  logic rxd_a;
  logic rxd_b;
  logic busy_a;
  logic busy_b;

  int checks   = 0;
  int failures = 0;
  int vcnt_a   = 0;
  int vcnt_b   = 0;
  int ocnt_a   = 0;
  int ocnt_b   = 0;

  exp_t qa[$];
  exp_t qb[$];

  uart_rx_core_if #(.DATA_BITS(8)) ifa ();
  uart_rx_core_if #(.DATA_BITS(8)) ifb ();

  uart_rx_core #(
    .CLK_FREQUENCY(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .rxd(rxd_a), .rx(ifa), .busy(busy_a)
  );

  uart_rx_core #(
    .CLK_FREQUENCY(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .clk(clk), .reset(reset), .rxd(rxd_b), .rx(ifb), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: pop on every accepting edge (valid & ready seen mid-cycle).
  always @(negedge clk) begin
    exp_t e;
    if (ifa.rx_valid)    vcnt_a++;
    if (ifa.overrun_err) ocnt_a++;
    if (ifa.rx_valid && ifa.rx_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_word", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_rx_data", int'(ifa.rx_data), int'(e.d));
        chk("a_frame_err", int'(ifa.frame_err), int'(e.fe));
        chk("a_parity_err", int'(ifa.parity_err), int'(e.pe));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ifb.rx_valid)    vcnt_b++;
    if (ifb.overrun_err) ocnt_b++;
    if (ifb.rx_valid && ifb.rx_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_word", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_rx_data", int'(ifb.rx_data), int'(e.d));
        chk("b_frame_err", int'(ifb.frame_err), int'(e.fe));
        chk("b_parity_err", int'(ifb.parity_err), int'(e.pe));
      end
    end
  end

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 0) rxd_a = v;
    else          rxd_b = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit par,
                            input logic pbit, input logic stopb);
    drive(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
    if (par) drive(sel, pbit, BIT);
    drive(sel, stopb, BIT);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    exp_t e;
    int   v0;
    int   o0;

    vecs[0]  = '{0, 8'hA5, 0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h00, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'hFF, 0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h5A, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[4]  = '{0, 8'h01, 0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{0, 8'h80, 0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6]  = '{1, 8'h07, 1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[7]  = '{1, 8'h07, 1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[8]  = '{1, 8'h00, 1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1, 8'h03, 1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    vecs[10] = '{1, 8'hFF, 1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{1, 8'hA5, 1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};

    reset = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    ifa.rx_ready = 1'b1;
    ifb.rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_rx_data", int'(ifa.rx_data), 0);
    chk("rst_rx_valid", int'(ifa.rx_valid), 0);
    chk("rst_frame_err", int'(ifa.frame_err), 0);
    chk("rst_parity_err", int'(ifa.parity_err), 0);
    chk("rst_overrun_err", int'(ifa.overrun_err), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);

    reset = 1'b1;
    drive(0, 1'b1, 2 * BIT);

    // Table of single frames, each must yield exactly one valid cycle.
    for (int i = 0; i < 12; i++) begin
      e.d  = vecs[i].exp_d;
      e.fe = vecs[i].exp_fe;
      e.pe = vecs[i].exp_pe;
      if (vecs[i].sel == 0) begin qa.push_back(e); v0 = vcnt_a; end
      else                  begin qb.push_back(e); v0 = vcnt_b; end
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].par, vecs[i].pbit, vecs[i].stopb);
      drive(vecs[i].sel, 1'b1, 2 * BIT);
      chk($sformatf("vec%0d_valid_cycles", i),
          (vecs[i].sel == 0) ? vcnt_a - v0 : vcnt_b - v0, 1);
      chk($sformatf("vec%0d_busy", i),
          (vecs[i].sel == 0) ? int'(busy_a) : int'(busy_b), 0);
    end

    // Stop bit low followed by a 3-bit break.
    e = '{8'h55, 1'b1, 1'b0};
    qa.push_back(e);
    v0 = vcnt_a;
    send_frame(0, 8'h55, 0, 1'b0, 1'b0);
    drive(0, 1'b0, 3 * BIT);
    chk("break_busy_held", int'(busy_a), 1);
    chk("break_one_word", vcnt_a - v0, 1);
    drive(0, 1'b1, 2 * BIT);
    chk("break_busy_released", int'(busy_a), 0);
    chk("break_no_retrigger", vcnt_a - v0, 1);
    e = '{8'h12, 1'b0, 1'b0};
    qa.push_back(e);
    send_frame(0, 8'h12, 0, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    chk("break_next_word", vcnt_a - v0, 2);

    // Short low glitch: detected, then rejected as a false start.
    v0 = vcnt_a;
    drive(0, 1'b0, 4);
    chk("glitch_busy_seen", int'(busy_a), 1);
    drive(0, 1'b1, 2 * BIT);
    chk("glitch_busy_clear", int'(busy_a), 0);
    chk("glitch_no_valid", vcnt_a - v0, 0);

    // Overrun: the second word is dropped while the first is held.
    ifa.rx_ready = 1'b0;
    e = '{8'h3C, 1'b0, 1'b0};
    qa.push_back(e);
    o0 = ocnt_a;
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    chk("ovr_first_valid", int'(ifa.rx_valid), 1);
    chk("ovr_first_data", int'(ifa.rx_data), 8'h3C);
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    chk("ovr_data_kept", int'(ifa.rx_data), 8'h3C);
    chk("ovr_valid_kept", int'(ifa.rx_valid), 1);
    chk("ovr_pulse_count", ocnt_a - o0, 1);
    ifa.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_valid_cleared", int'(ifa.rx_valid), 0);
    drive(0, 1'b1, 3 * BIT);
    chk("ovr_no_second_word", int'(ifa.rx_valid), 0);
    chk("ovr_queue_drained", qa.size(), 0);

    // Reset in the middle of data bit 3 of 0xE7.
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 3; i++) drive(0, 1'(8'hE7 >> i), BIT);
    drive(0, 1'b0, BIT / 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_rx_data", int'(ifa.rx_data), 0);
    chk("mid_rst_rx_valid", int'(ifa.rx_valid), 0);
    drive(0, 1'b0, BIT / 2);
    for (int i = 4; i < 8; i++) drive(0, 1'(8'hE7 >> i), BIT);
    drive(0, 1'b1, 2 * BIT);
    reset = 1'b1;
    drive(0, 1'b1, BIT);
    chk("post_rst_busy", int'(busy_a), 0);
    v0 = vcnt_a;
    e = '{8'h81, 1'b0, 1'b0};
    qa.push_back(e);
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    drive(0, 1'b1, 2 * BIT);
    chk("post_rst_one_word", vcnt_a - v0, 1);

    chk("final_queue_a", qa.size(), 0);
    chk("final_queue_b", qb.size(), 0);
    chk("final_overrun_b", ocnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
